// File: rtl/riscv_mem_arbiter_if.sv
// Fetch port, data port and single-port RAM port of the memory arbiter bundled as one interface.
// slave = arbiter view, master = core/RAM environment view.
interface riscv_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter onto one single-port RAM: combinational grant, read data 1 cycle after grant.
// No request buffer: the loser holds its request; fetch is forced through after STARVE_MAX data grants.
module riscv_mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                x_reset,
  riscv_mem_arbiter_if.slave bus
);
  localparam int            CW      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } own_e;

  own_e          rsp_own, rsp_own_nxt;
  logic [CW-1:0] starve_cnt, starve_cnt_nxt;
  logic          grant_if, grant_d;

  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      rsp_own    <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      rsp_own    <= rsp_own_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    grant_if       = 1'b0;
    grant_d        = 1'b0;
    starve_cnt_nxt = '0;
    rsp_own_nxt    = OWN_NONE;

    // Data normally wins; once the pending fetch has lost STARVE_MAX times it takes the slot.
    if (bus.d_req && !(bus.if_req && starve_cnt == CNT_MAX)) begin
      grant_d = 1'b1;
    end else if (bus.if_req) begin
      grant_if = 1'b1;
    end

    if (grant_d && bus.if_req) begin
      starve_cnt_nxt = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + CW'(1);
    end

    if (grant_if) begin
      rsp_own_nxt = OWN_IF;
    end else if (grant_d && !bus.d_we) begin
      rsp_own_nxt = OWN_D;
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.d_gnt     = grant_d;
  assign bus.mem_en    = grant_if | grant_d;
  assign bus.mem_we    = grant_d & bus.d_we;
  assign bus.mem_addr  = grant_d ? bus.d_addr : (grant_if ? bus.if_addr : 32'h0);
  assign bus.mem_wdata = grant_d ? bus.d_wdata : 32'h0;

  assign bus.if_rvalid = (rsp_own == OWN_IF);
  assign bus.d_rvalid  = (rsp_own == OWN_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : 32'h0;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed stimulus pushes expected grants/responses into queues; a negedge monitor pops and compares.
module tb_riscv_mem_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int W_NONE = 0;
  localparam int W_IF   = 1;
  localparam int W_D    = 2;

  logic clk = 1'b0;
  logic x_reset;

  riscv_mem_arbiter_if bus();

  riscv_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk     (clk),
    .x_reset (x_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_en;
    logic        if_gnt;
    logic        d_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } gnt_t;

  typedef struct packed {
    logic        if_rvalid;
    logic        d_rvalid;
    logic [31:0] if_rdata;
    logic [31:0] d_rdata;
  } rsp_t;

  gnt_t        gq[$];
  rsp_t        rq[$];
  gnt_t        ag;
  rsp_t        ar;
  int          checks = 0;
  int          passes = 0;
  bit          mon_en = 1'b0;
  logic        rd_pend;
  logic [31:0] rd_addr;

  function automatic logic [31:0] ram_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input logic [95:0] act);
    checks++;
    $display("FAIL %s: got %h, expected nothing", name, act);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      ag = gnt_t'{bus.mem_en, bus.if_gnt, bus.d_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata};
      ar = rsp_t'{bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata};
      if (bus.mem_en || bus.if_gnt || bus.d_gnt) begin
        if (gq.size() == 0) fail_now("unexpected_grant", 96'(ag));
        else check("grant", 96'(ag), 96'(gq.pop_front()));
      end else begin
        check("idle_bus", 96'(ag), 96'(0));
      end
      if (bus.if_rvalid || bus.d_rvalid) begin
        if (rq.size() == 0) fail_now("unexpected_rsp", 96'(ar));
        else check("rsp", 96'(ar), 96'(rq.pop_front()));
      end else begin
        check("no_rsp_rdata", 96'(ar), 96'(0));
      end
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dd;
  endtask

  task automatic expect_grant(input int win, input logic [31:0] ia, input logic dw,
                              input logic [31:0] da, input logic [31:0] dd, input bit with_rsp);
    if (win == W_IF) begin
      gq.push_back(gnt_t'{1'b1, 1'b1, 1'b0, 1'b0, ia, 32'h0});
      if (with_rsp) rq.push_back(rsp_t'{1'b1, 1'b0, ram_val(ia), 32'h0});
    end else if (win == W_D) begin
      gq.push_back(gnt_t'{1'b1, 1'b0, 1'b1, dw, da, dd});
      if (with_rsp && !dw) rq.push_back(rsp_t'{1'b0, 1'b1, 32'h0, ram_val(da)});
    end
  endtask

  // One cycle: drive at posedge+1, monitor samples at negedge, RAM returns data at next posedge+1.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                      input logic dw, input logic [31:0] da, input logic [31:0] dd, input int win);
    drive(ir, ia, dr, dw, da, dd);
    expect_grant(win, ia, dw, da, dd, 1'b1);
    @(negedge clk);
    rd_pend = bus.mem_en && !bus.mem_we;
    rd_addr = bus.mem_addr;
    @(posedge clk);
    #1;
    bus.mem_rdata = rd_pend ? ram_val(rd_addr) : 32'hBAD0_BAD0;
  endtask

  initial begin
    int cont_win[10];
    logic [31:0] ia;
    cont_win = '{W_D, W_D, W_D, W_D, W_IF, W_D, W_D, W_D, W_D, W_IF};

    x_reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_rdata = 32'hBAD0_BAD0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rvalid", 96'({bus.if_rvalid, bus.d_rvalid}), 96'(0));
    check("reset_rdata", 96'({bus.if_rdata, bus.d_rdata}), 96'(0));
    check("reset_starve_cnt", 96'(dut.starve_cnt), 96'(0));
    x_reset = 1'b1;
    mon_en  = 1'b1;

    // fetch only, then store only
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, W_IF);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, W_NONE);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, W_D);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, W_NONE);

    // contention: loads and a held fetch for 10 cycles
    ia = 32'h400;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, ia, 1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h1111_0000 + 32'(i), cont_win[i]);
      if (cont_win[i] == W_IF) ia = ia + 32'h4;
    end

    // alternating fetch/load, back-to-back
    step(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, W_IF);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h800, 32'h0, W_D);
    step(1'b1, 32'h704, 1'b0, 1'b0, 32'h0, 32'h0, W_IF);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h804, 32'h0, W_D);

    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, W_NONE);
    check("idle_starve_cnt", 96'(dut.starve_cnt), 96'(0));

    // build up starvation, then reset right after a load grant
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h500, 1'b1, 1'b0, 32'h600 + 32'(4 * i), 32'h0, W_D);
    drive(1'b1, 32'h500, 1'b1, 1'b0, 32'h60C, 32'h0);
    expect_grant(W_D, 32'h500, 1'b0, 32'h60C, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    x_reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_rdata = 32'hBAD0_BAD0;
    #1;
    check("midreset_starve_cnt", 96'(dut.starve_cnt), 96'(0));
    @(posedge clk);
    #1;
    bus.mem_rdata = ram_val(32'h60C);
    check("midreset_d_rvalid", 96'({bus.d_rvalid, bus.d_rdata}), 96'(0));
    @(posedge clk);
    #1;
    x_reset = 1'b1;

    // first arbitration after release starts from starve_cnt=0
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h900, 1'b1, 1'b0, 32'hA00 + 32'(4 * i), 32'h0, cont_win[i]);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, W_NONE);

    check("grant_queue_drained", 96'(gq.size()), 96'(0));
    check("rsp_queue_drained", 96'(rq.size()), 96'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4: the number of consecutive data grants allowed while a fetch is pending.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port x_reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port if_req, input, 1 bit: instruction-fetch read request.
REQ-005 The block SHALL have port if_addr, input, 32 bits: fetch byte address.
REQ-006 The block SHALL have port if_gnt, output, 1 bit: fetch request accepted this cycle.
REQ-007 The block SHALL have port if_rvalid, output, 1 bit: fetch read data valid.
REQ-008 The block SHALL have port if_rdata, output, 32 bits: fetch read data.
REQ-009 The block SHALL have port d_req, input, 1 bit: load/store request.
REQ-010 The block SHALL have port d_we, input, 1 bit: 1 = store, 0 = load.
REQ-011 The block SHALL have port d_addr, input, 32 bits: data byte address.
REQ-012 The block SHALL have port d_wdata, input, 32 bits: store data.
REQ-013 The block SHALL have port d_gnt, output, 1 bit: data request accepted this cycle.
REQ-014 The block SHALL have port d_rvalid, output, 1 bit: load data valid.
REQ-015 The block SHALL have port d_rdata, output, 32 bits: load data.
REQ-016 The block SHALL have port mem_en, output, 1 bit: single-port RAM access strobe.
REQ-017 The block SHALL have port mem_we, output, 1 bit: RAM write enable.
REQ-018 The block SHALL have port mem_addr, output, 32 bits: RAM address.
REQ-019 The block SHALL have port mem_wdata, output, 32 bits: RAM write data.
REQ-020 The block SHALL have port mem_rdata, input, 32 bits: RAM read data, valid exactly 1 cycle after a read strobe.

Function
REQ-021 The block SHALL issue at most one RAM access per cycle; if_gnt and d_gnt are never both 1.
REQ-022 Grant SHALL be combinational in the request cycle: a granted requester's addr/we/wdata drive mem_* that same cycle, with mem_en=1.
REQ-023 mem_we SHALL equal d_we on a data grant and 0 on a fetch grant; mem_wdata SHALL equal d_wdata on a data grant, else 0.
REQ-024 Priority: d_req alone grants data; if_req alone grants fetch; when both are asserted, data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
REQ-025 starve_cnt (saturating, width clog2(STARVE_MAX+1)) SHALL increment on each data grant with if_req=1, and clear on a fetch grant or when if_req=0.
REQ-026 With no request: mem_en=0, mem_we=0, mem_addr=0, and no grant.
REQ-027 A response-owner register rsp_own ∈ {NONE, IF, D} SHALL be loaded each cycle: IF on a fetch grant, D on a load grant, NONE otherwise (stores and idle cycles).
REQ-028 if_rvalid SHALL be 1 iff rsp_own==IF; d_rvalid SHALL be 1 iff rsp_own==D.
REQ-029 Read latency SHALL be exactly 1 cycle from grant to rvalid.
REQ-030 Each rdata SHALL equal mem_rdata while its rvalid=1, and 0 otherwise.
REQ-031 Stores SHALL complete at grant and produce no rvalid.
REQ-032 Back-to-back grants SHALL be supported: a new grant may occur in the same cycle as the previous response.
REQ-033 Requesters SHALL hold req/addr/wdata stable until granted; the block keeps no request buffer.

Reset
REQ-034 While x_reset=0: rsp_own=NONE, starve_cnt=0, if_rvalid=0, d_rvalid=0, and both rdata outputs are 0, asynchronously.
REQ-035 A read granted in the cycle before reset assertion SHALL produce no rvalid after reset release.
REQ-036 After reset release, the first cycle SHALL arbitrate normally with starve_cnt=0.

Verification
REQ-037 Fetch only: if_req=1, if_addr=0x100 → if_gnt=1, mem_addr=0x100, mem_we=0; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-038 Store only: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF → d_gnt=1, mem_we=1, mem_wdata=0xDEADBEEF; next cycle d_rvalid=0.
REQ-039 Contention, STARVE_MAX=4: if_req and d_req (loads) held high for 10 cycles → grants D,D,D,D,IF,D,D,D,D,IF; rvalid owners follow one cycle later.
REQ-040 Alternating fetch/load grants → each rvalid arrives exactly 1 cycle after its grant; no cycle asserts both rvalids.
REQ-041 Reset mid-operation: load granted, then x_reset=0 before the next edge → d_rvalid stays 0; after release, the first request is granted with starve_cnt=0.
REQ-042 Idle: no requests for 5 cycles → mem_en=0 throughout, all rvalid=0, starve_cnt=0.
